// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
// Takes per-channel RGB duty values over a valid/ready handshake and drives
// three active-low LED pins with PWM. A received colour waits in a pending
// buffer and is copied to the active registers only when the PWM counter
// wraps, so a period is never split between two colours.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           asynchronous active-low reset
//   in_valid      upstream presents a colour on in_r/in_g/in_b
//   in_ready      pending buffer is empty and can take a colour
//   in_r/g/b      per-channel duty (ticks per period the LED is lit)
//   led_r/g/b     registered active-low LED drives (0 = lit)
//   period_start  registered one-cycle pulse in the first cycle of a period
module rgb_pwm_driver #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_g,
  input  logic [WIDTH-1:0] in_b,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] PWM_LAST = {WIDTH{1'b1}};

  logic [PW-1:0]    pre_cnt_r;
  logic [WIDTH-1:0] pwm_cnt_r;
  logic [WIDTH-1:0] pending_red_r;
  logic [WIDTH-1:0] pending_grn_r;
  logic [WIDTH-1:0] pending_blu_r;
  logic             pending_full_r;
  logic [WIDTH-1:0] active_red_r;
  logic [WIDTH-1:0] active_grn_r;
  logic [WIDTH-1:0] active_blu_r;
  logic             led_r_r;
  logic             led_g_r;
  logic             led_b_r;
  logic             period_start_r;

  logic tick_s;
  logic wrap_s;
  logic accept_s;
  logic commit_s;

  // Tick, wrap, transfer and commit strobes.
  always_comb begin
    tick_s   = 1'b0;
    wrap_s   = 1'b0;
    accept_s = 1'b0;
    commit_s = 1'b0;
    if (pre_cnt_r == PRE_LAST) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    if (tick_s && (pwm_cnt_r == PWM_LAST)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
    // The buffer is only written while empty and only drained while full,
    // so a transfer and a commit are mutually exclusive.
    if (in_valid && !pending_full_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (wrap_s && pending_full_r) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Prescaler: divides clk down to PWM ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_r <= '0;
    end else if (tick_s) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + PW'(1);
    end
  end

  // PWM counter: advances once per tick, wraps naturally at 2^WIDTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_r <= '0;
    end else if (tick_s) begin
      pwm_cnt_r <= pwm_cnt_r + WIDTH'(1);
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Pending buffer: filled by a transfer, drained at a period boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_red_r  <= '0;
      pending_grn_r  <= '0;
      pending_blu_r  <= '0;
      pending_full_r <= 1'b0;
    end else if (accept_s) begin
      pending_red_r  <= in_r;
      pending_grn_r  <= in_g;
      pending_blu_r  <= in_b;
      pending_full_r <= 1'b1;
    end else if (commit_s) begin
      pending_full_r <= 1'b0;
    end else begin
      pending_full_r <= pending_full_r;
    end
  end

  // Active duty registers: only change at a wrap with a colour waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_red_r <= '0;
      active_grn_r <= '0;
      active_blu_r <= '0;
    end else if (commit_s) begin
      active_red_r <= pending_red_r;
      active_grn_r <= pending_grn_r;
      active_blu_r <= pending_blu_r;
    end else begin
      active_red_r <= active_red_r;
      active_grn_r <= active_grn_r;
      active_blu_r <= active_blu_r;
    end
  end

  // Registered LED compare and period marker; one cycle behind the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_r_r        <= 1'b1;
      led_g_r        <= 1'b1;
      led_b_r        <= 1'b1;
      period_start_r <= 1'b0;
    end else begin
      led_r_r        <= ~(pwm_cnt_r < active_red_r);
      led_g_r        <= ~(pwm_cnt_r < active_grn_r);
      led_b_r        <= ~(pwm_cnt_r < active_blu_r);
      period_start_r <= wrap_s;
    end
  end

  assign in_ready     = ~pending_full_r;
  assign led_r        = led_r_r;
  assign led_g        = led_g_r;
  assign led_b        = led_b_r;
  assign period_start = period_start_r;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
module tb_rgb_pwm_driver;

  logic       clk;
  logic       rst_a;
  logic       in_valid_a;
  logic       in_ready_a;
  logic [7:0] in_r_a, in_g_a, in_b_a;
  logic       led_r_a, led_g_a, led_b_a;
  logic       period_start_a;

  logic       rst_b;
  logic       in_valid_b;
  logic       in_ready_b;
  logic [3:0] in_r_b, in_g_b, in_b_b;
  logic       led_r_b, led_g_b, led_b_b;
  logic       period_start_b;

  int passed;
  int total;
  int cyc;
  int lo_r, lo_g, lo_b, ps_cnt, rdy_cnt;

  rgb_pwm_driver #(.WIDTH(8), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_r(in_r_a), .in_g(in_g_a), .in_b(in_b_a),
    .led_r(led_r_a), .led_g(led_g_a), .led_b(led_b_a),
    .period_start(period_start_a)
  );

  rgb_pwm_driver #(.WIDTH(4), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_r(in_r_b), .in_g(in_g_b), .in_b(in_b_b),
    .led_r(led_r_b), .led_g(led_g_b), .led_b(led_b_b),
    .period_start(period_start_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_counts();
    lo_r = 0; lo_g = 0; lo_b = 0; ps_cnt = 0; rdy_cnt = 0;
  endtask

  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (!led_r_a) lo_r++;
      if (!led_g_a) lo_g++;
      if (!led_b_a) lo_b++;
      if (period_start_a) ps_cnt++;
      if (in_ready_a) rdy_cnt++;
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if ({led_r_a, led_g_a, led_b_a} !== 3'b111) $display("FAIL reset_leds: got %b expected 111", {led_r_a, led_g_a, led_b_a});
    else passed++;
    total++;
    if (period_start_a !== 1'b0) $display("FAIL reset_period_start: got %b expected 0", period_start_a);
    else passed++;
    total++;
    if (in_ready_a !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready_a);
    else passed++;
  endtask

  task automatic test_first_colour();
    rst_a = 1'b1;
    in_r_a = 8'd64; in_g_a = 8'd0; in_b_a = 8'd255;
    in_valid_a = 1'b1;
    cyc = 0;
    total++;
    if (in_ready_a !== 1'b1) $display("FAIL first_ready_before: got %b expected 1", in_ready_a);
    else passed++;
    step();
    total++;
    if (in_ready_a !== 1'b0) $display("FAIL first_ready_after_xfer: got %b expected 0", in_ready_a);
    else passed++;
    in_valid_a = 1'b0;
    clear_counts();
    run_count(1022);
    total++;
    if (lo_r + lo_g + lo_b !== 0) $display("FAIL first_leds_dark: got %0d lit samples expected 0", lo_r + lo_g + lo_b);
    else passed++;
    total++;
    if (ps_cnt !== 0 || rdy_cnt !== 0) $display("FAIL first_idle: got ps=%0d ready=%0d expected 0 0", ps_cnt, rdy_cnt);
    else passed++;
    run_count(1);
    total++;
    if (period_start_a !== 1'b1) $display("FAIL first_period_start_1024: got %b expected 1 at cycle %0d", period_start_a, cyc);
    else passed++;
    total++;
    if (in_ready_a !== 1'b1 || {led_r_a, led_g_a, led_b_a} !== 3'b111) $display("FAIL first_commit_state: got ready=%b leds=%b expected 1 111", in_ready_a, {led_r_a, led_g_a, led_b_a});
    else passed++;
  endtask

  task automatic test_steady();
    clear_counts();
    run_count(1024);
    total++;
    if (lo_r !== 256 || lo_g !== 0 || lo_b !== 1020) $display("FAIL steady_duty: got %0d %0d %0d expected 256 0 1020", lo_r, lo_g, lo_b);
    else passed++;
    total++;
    if (ps_cnt !== 1 || period_start_a !== 1'b1) $display("FAIL steady_period_start: got count=%0d last=%b expected 1 1", ps_cnt, period_start_a);
    else passed++;
  endtask

  task automatic test_back_to_back();
    in_r_a = 8'd32; in_g_a = 8'd200; in_b_a = 8'd100;
    in_valid_a = 1'b1;
    step();
    total++;
    if (in_ready_a !== 1'b0) $display("FAIL b2b_a_accept: got %b expected 0", in_ready_a);
    else passed++;
    in_r_a = 8'd10; in_g_a = 8'd20; in_b_a = 8'd30;
    clear_counts();
    run_count(1022);
    total++;
    if (rdy_cnt !== 0) $display("FAIL b2b_stall: got %0d ready cycles expected 0", rdy_cnt);
    else passed++;
    run_count(1);
    total++;
    if (in_ready_a !== 1'b1 || period_start_a !== 1'b1) $display("FAIL b2b_wrap: got ready=%b ps=%b expected 1 1 at cycle %0d", in_ready_a, period_start_a, cyc);
    else passed++;
    clear_counts();
    run_count(1);
    total++;
    if (in_ready_a !== 1'b0) $display("FAIL b2b_b_accept: got %b expected 0", in_ready_a);
    else passed++;
    in_valid_a = 1'b0;
    run_count(1023);
    total++;
    if (lo_r !== 128 || lo_g !== 800 || lo_b !== 400) $display("FAIL b2b_a_period: got %0d %0d %0d expected 128 800 400", lo_r, lo_g, lo_b);
    else passed++;
    total++;
    if (in_ready_a !== 1'b1) $display("FAIL b2b_b_commit_ready: got %b expected 1", in_ready_a);
    else passed++;
    clear_counts();
    run_count(1024);
    total++;
    if (lo_r !== 40 || lo_g !== 80 || lo_b !== 120) $display("FAIL b2b_b_period: got %0d %0d %0d expected 40 80 120", lo_r, lo_g, lo_b);
    else passed++;
  endtask

  task automatic test_duty_zero();
    in_r_a = 8'd0; in_g_a = 8'd0; in_b_a = 8'd0;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    clear_counts();
    run_count(1023);
    total++;
    if (ps_cnt !== 1 || period_start_a !== 1'b1) $display("FAIL zero_commit_wrap: got count=%0d last=%b expected 1 1", ps_cnt, period_start_a);
    else passed++;
    clear_counts();
    run_count(3072);
    total++;
    if (lo_r + lo_g + lo_b !== 0) $display("FAIL zero_leds_dark: got %0d lit samples expected 0", lo_r + lo_g + lo_b);
    else passed++;
    total++;
    if (ps_cnt !== 3) $display("FAIL zero_period_pulses: got %0d expected 3", ps_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    in_r_a = 8'd128; in_g_a = 8'd128; in_b_a = 8'd128;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    run_count(1023);
    in_r_a = 8'd1; in_g_a = 8'd2; in_b_a = 8'd3;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    run_count(99);
    total++;
    if ({led_r_a, led_g_a, led_b_a} !== 3'b000 || in_ready_a !== 1'b0) $display("FAIL mid_precondition: got leds=%b ready=%b expected 000 0", {led_r_a, led_g_a, led_b_a}, in_ready_a);
    else passed++;
    #3;
    rst_a = 1'b0;
    #1;
    total++;
    if ({led_r_a, led_g_a, led_b_a} !== 3'b111) $display("FAIL mid_async_leds: got %b expected 111", {led_r_a, led_g_a, led_b_a});
    else passed++;
    total++;
    if (in_ready_a !== 1'b1 || period_start_a !== 1'b0) $display("FAIL mid_async_ctrl: got ready=%b ps=%b expected 1 0", in_ready_a, period_start_a);
    else passed++;
    step();
    step();
    rst_a = 1'b1;
    cyc = 0;
    clear_counts();
    run_count(1100);
    total++;
    if (lo_r + lo_g + lo_b !== 0) $display("FAIL mid_no_stale_colour: got %0d lit samples expected 0", lo_r + lo_g + lo_b);
    else passed++;
    total++;
    if (ps_cnt !== 1 || rdy_cnt !== 1100) $display("FAIL mid_after_release: got ps=%0d ready=%0d expected 1 1100", ps_cnt, rdy_cnt);
    else passed++;
  endtask

  task automatic test_prescale1();
    int ps_bad, slo_r, slo_g, slo_b, early_lit;
    logic g17, g18, r31, r32;
    ps_bad = 0; slo_r = 0; slo_g = 0; slo_b = 0; early_lit = 0;
    g17 = 1'b1; g18 = 1'b0; r31 = 1'b1; r32 = 1'b0;
    rst_b = 1'b1;
    in_r_b = 4'd15; in_g_b = 4'd1; in_b_b = 4'd8;
    in_valid_b = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        total++;
        if (in_ready_b !== 1'b0) $display("FAIL p1_accept: got %b expected 0", in_ready_b);
        else passed++;
        in_valid_b = 1'b0;
      end
      if (period_start_b !== ((k % 16) == 0)) ps_bad++;
      if (k <= 16 && {led_r_b, led_g_b, led_b_b} !== 3'b111) early_lit++;
      if (k >= 17 && k <= 32) begin
        if (!led_r_b) slo_r++;
        if (!led_g_b) slo_g++;
        if (!led_b_b) slo_b++;
      end
      if (k == 17) g17 = led_g_b;
      if (k == 18) g18 = led_g_b;
      if (k == 31) r31 = led_r_b;
      if (k == 32) r32 = led_r_b;
    end
    total++;
    if (ps_bad !== 0) $display("FAIL p1_period_start: got %0d misplaced cycles expected 0", ps_bad);
    else passed++;
    total++;
    if (early_lit !== 0) $display("FAIL p1_dark_first_period: got %0d lit samples expected 0", early_lit);
    else passed++;
    total++;
    if (slo_r !== 15 || slo_g !== 1 || slo_b !== 8) $display("FAIL p1_duty: got %0d %0d %0d expected 15 1 8", slo_r, slo_g, slo_b);
    else passed++;
    total++;
    if (g17 !== 1'b0 || g18 !== 1'b1) $display("FAIL p1_green_edge: got %b%b expected 01", g17, g18);
    else passed++;
    total++;
    if (r31 !== 1'b0 || r32 !== 1'b1) $display("FAIL p1_red_edge: got %b%b expected 01", r31, r32);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    cyc    = 0;
    clear_counts();
    rst_a = 1'b1; rst_b = 1'b1;
    in_valid_a = 1'b0; in_r_a = 8'd0; in_g_a = 8'd0; in_b_a = 8'd0;
    in_valid_b = 1'b0; in_r_b = 4'd0; in_g_b = 4'd0; in_b_b = 4'd0;
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_reset();
    test_first_colour();
    test_steady();
    test_back_to_back();
    test_duty_zero();
    test_reset_mid();
    test_prescale1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream stage for the colour-producing logic. It accepts per-channel RGB duty values over a valid/ready handshake and drives the three active-low board LED pins (led_r, led_g, led_b) with PWM. New colours are double-buffered and applied only at a PWM period boundary, so there is no glitching mid-period.

Parameters:
WIDTH, 8, duty and PWM counter width; the period is 2^WIDTH PWM ticks.
PRESCALE, 16, clk cycles per PWM tick; legal range >= 1.

Ports:
clk  input  1  system clock; all logic is on posedge.
rst  input  1  reset, asynchronous, active-low. Asserting rst low clears all state immediately. Release is sampled on clk.
in_valid  input  1  upstream presents a colour on in_r/in_g/in_b.
in_ready  output  1  driver can accept a colour; equals !pending_full.
in_r  input  WIDTH  red duty: number of ticks per period the LED is on.
in_g  input  WIDTH  green duty.
in_b  input  WIDTH  blue duty.
led_r  output  1  red LED, active-low (0 = lit); registered.
led_g  output  1  green LED, active-low; registered.
led_b  output  1  blue LED, active-low; registered.
period_start  output  1  one-cycle pulse, registered, marks PWM counter wrap to 0.

Behaviour:
- State:
  - pre_cnt: 0..PRESCALE-1.
  - pwm_cnt: WIDTH bits.
  - pending_r/g/b and pending_full.
  - active_r/g/b.
- Reset (rst low):
  - pre_cnt, pwm_cnt, pending, active = 0; pending_full = 0.
  - led_r/g/b = 1 (all off); period_start = 0.
  - in_ready = 1, since it is combinational from pending_full.
- Prescaler:
  - tick = (pre_cnt == PRESCALE-1).
  - On tick, pre_cnt <= 0; otherwise pre_cnt increments.
  - PRESCALE = 1 gives tick every cycle.
- PWM counter:
  - pwm_cnt increments on tick, wrapping 2^WIDTH-1 -> 0.
  - wrap = tick && pwm_cnt == 2^WIDTH-1.
- Handshake:
  - A transfer happens on a posedge with in_valid && in_ready. It captures in_* into pending and sets pending_full.
  - in_ready is low while pending_full is set. in_valid held while in_ready is low is ignored; upstream must keep the data stable until the transfer.
- Commit:
  - On a wrap cycle with pending_full = 1: active <= pending and pending_full <= 0. in_ready rises the following cycle.
  - On a wrap with pending_full = 0, active is unchanged.
  - A transfer cannot coincide with a commit, because in_ready = 0 whenever pending_full = 1.
- Outputs:
  - Every cycle, led_x <= !(pwm_cnt < active_x), an unsigned compare. This is a 1-cycle latency from the counter/active state.
  - Duty 0 keeps the LED permanently off.
  - Duty 2^WIDTH-1 lights the LED for 2^WIDTH-1 of 2^WIDTH ticks. Full-on is not reachable by design.
- period_start <= wrap. It is high exactly in the first cycle where pwm_cnt == 0, once per 2^WIDTH*PRESCALE cycles.
- First colour after reset:
  - It is accepted on the first valid cycle.
  - It takes effect at the first wrap, 2^WIDTH*PRESCALE cycles after reset release. LEDs stay off until then.
- Reset mid-operation: all state is cleared asynchronously. A pending colour is discarded and LEDs go off in the same cycle as the rst assertion, without waiting for clk.

Test Plan:
- Reset and first colour:
  - Stimulus: WIDTH=8, PRESCALE=4; release rst; send (64,0,255) on the first cycle.
  - Required: in_ready=1 during and after reset, dropping low for the cycle after the transfer. LEDs stay high until the first period_start, at cycle 1024.
- Steady-state duty:
  - Stimulus: same colour (64,0,255), observed over one full period after the first commit.
  - Required, per 1024-cycle period: led_r low for 256 cycles; led_g never low; led_b low for 1020 cycles.
- Back-to-back colours:
  - Stimulus: send colour A, then assert colour B immediately.
  - Required: B stalls (in_ready=0) until the cycle after the next wrap. B is accepted then and becomes active at the following wrap; A is active for exactly one period.
- PRESCALE=1, WIDTH=4:
  - Stimulus: duty (15,1,8).
  - Required: period_start every 16 cycles. Per period, LEDs low for 15, 1 and 8 cycles respectively; the led edge trails the pwm_cnt compare by 1 cycle.
- Reset mid-period:
  - Stimulus: assert rst mid-period with pending_full = 1 and active (128,128,128).
  - Required: LEDs go high asynchronously; after release in_ready=1, and no colour is applied until a new transfer commits at a wrap.
- Duty zero:
  - Stimulus: after duty (0,0,0) is committed, run 3 periods.
  - Required: all LEDs remain 1 continuously; period_start pulses 3 times.
